// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer. One shared shift-add / restoring-subtract
// datapath is stepped one bit per clock. MUL returns the low WIDTH product bits;
// UDIV/SDIV return the truncated quotient. A zero divisor completes early with
// div_by_zero set and result 0.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  typedef enum logic [2:0] {IDLE, SETUP, ITER, FIXUP, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       op_q;
  logic             sign;
  logic             dz;
  // acc: product accumulator (MUL) or partial remainder (DIV)
  // md : shifting multiplicand (MUL) or divisor (DIV)
  // mq : shifting multiplier (MUL) or dividend/quotient (DIV)
  logic [WIDTH-1:0] acc, md, mq;

  logic is_div, is_sdiv;
  assign is_div  = (op_q != 2'b00);
  assign is_sdiv = (op_q == 2'b10);

  logic [WIDTH-1:0] abs_a, abs_b;
  assign abs_a = a_q[WIDTH-1] ? (~a_q + 1'b1) : a_q;
  assign abs_b = b_q[WIDTH-1] ? (~b_q + 1'b1) : b_q;

  // Restoring step. The shifted remainder is kept WIDTH+1 bits wide so that
  // divisors with the MSB set still compare correctly; the borrow out of the
  // subtract is the "remainder < divisor" flag.
  logic [WIDTH:0] rem_sh, rem_diff;
  logic           rem_ge;
  assign rem_sh   = {acc, mq[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, md};
  assign rem_ge   = ~rem_diff[WIDTH];

  // Control FSM and datapath; all outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      sign        <= 1'b0;
      dz          <= 1'b0;
      acc         <= '0;
      md          <= '0;
      mq          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q         <= a;
            b_q         <= b;
            op_q        <= op;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            state       <= SETUP;
          end
        end
        SETUP: begin
          cnt  <= CNT_W'(WIDTH-1);
          acc  <= '0;
          sign <= 1'b0;
          dz   <= 1'b0;
          if (is_div) begin
            md    <= is_sdiv ? abs_b : b_q;
            mq    <= is_sdiv ? abs_a : a_q;
            sign  <= is_sdiv & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            // Zero divisor skips the iterations; passing through FIXUP keeps
            // the completion two edges after the start edge.
            if (b_q == '0) begin
              dz    <= 1'b1;
              state <= FIXUP;
            end else begin
              state <= ITER;
            end
          end else begin
            md    <= a_q;
            mq    <= b_q;
            state <= ITER;
          end
        end
        ITER: begin
          cnt <= cnt - 1'b1;
          if (is_div) begin
            acc <= rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            mq  <= {mq[WIDTH-2:0], rem_ge};
          end else begin
            if (mq[0]) acc <= acc + md;
            md <= md << 1;
            mq <= mq >> 1;
          end
          if (cnt == '0) state <= FIXUP;
        end
        FIXUP: begin
          done  <= 1'b1;
          state <= DONE;
          if (dz) begin
            result      <= '0;
            div_by_zero <= 1'b1;
          end else if (is_div) begin
            result <= sign ? (~mq + 1'b1) : mq;
          end else begin
            result <= acc;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: products, quotients, zero divisor, ignored
// starts while busy, held start, and mid-operation reset.
module tb_muldiv_seq;

  logic        clk, reset, start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;
  int lat;

  muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation; lat = edges from the start edge to the first edge
  // after which done is seen high. poke>=0 pulses a bogus start mid-run;
  // hold keeps start asserted throughout.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int poke, input bit hold, output int n);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    chk("busy_rise", {31'd0, busy}, 32'd1);
    if (!hold) begin
      start = 1'b0; a = '1; b = '1;
    end
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      if (n == poke) begin
        start = 1'b1; a = 32'd9; b = 32'd9;
      end else if (!hold) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    chk("busy_at_done", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("done_single", {31'd0, done}, 32'd0);
    chk("busy_fall", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_dz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk) reset = 1'b0;

    // Multiply
    run_op(2'b00, 32'd7, 32'd6, -1, 1'b0, lat);
    chk("mul7x6_lat", lat, 32'd34);
    chk("mul7x6", result, 32'd42);
    run_op(2'b00, 32'hFFFF_FFFF, 32'd2, -1, 1'b0, lat);
    chk("mul_ffx2", result, 32'hFFFF_FFFE);

    // Unsigned divide
    run_op(2'b01, 32'd100, 32'd7, -1, 1'b0, lat);
    chk("udiv100_7_lat", lat, 32'd34);
    chk("udiv100_7", result, 32'd14);
    chk("udiv100_7_dz", {31'd0, div_by_zero}, 32'd0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, -1, 1'b0, lat);
    chk("udiv_ff_1", result, 32'hFFFF_FFFF);
    run_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, -1, 1'b0, lat);
    chk("udiv_bigdivisor_op11", result, 32'd1);

    // Signed divide
    run_op(2'b10, 32'hFFFF_FF9C, 32'd7, -1, 1'b0, lat);
    chk("sdiv_m100_7", result, 32'hFFFF_FFF2);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, lat);
    chk("sdiv_min_m1", result, 32'h8000_0000);
    run_op(2'b10, 32'd100, 32'hFFFF_FFF9, -1, 1'b0, lat);
    chk("sdiv_100_m7", result, 32'hFFFF_FFF2);

    // Divide by zero, then a MUL clears the flag
    run_op(2'b01, 32'd5, 32'd0, -1, 1'b0, lat);
    chk("div0_lat", lat, 32'd2);
    chk("div0_result", result, 32'd0);
    chk("div0_flag", {31'd0, div_by_zero}, 32'd1);
    run_op(2'b00, 32'd3, 32'd5, -1, 1'b0, lat);
    chk("mul_after_div0_flag", {31'd0, div_by_zero}, 32'd0);
    chk("mul_after_div0", result, 32'd15);

    // Start pulsed mid-operation is ignored
    run_op(2'b00, 32'd3, 32'd4, 10, 1'b0, lat);
    chk("ignore_start_lat", lat, 32'd34);
    chk("ignore_start", result, 32'd12);

    // Start held high: re-accepted only once back in IDLE
    run_op(2'b00, 32'd5, 32'd5, -1, 1'b1, lat);
    chk("hold_first", result, 32'd25);
    @(posedge clk); #1;
    chk("hold_reaccept", {31'd0, busy}, 32'd1);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hold_second_lat", lat, 32'd34);
    chk("hold_second", result, 32'd25);
    @(posedge clk); #1;

    // Reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_result", result, 32'd0);
    @(negedge clk) reset = 1'b0;
    lat = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done === 1'b1) lat++;
    end
    chk("no_done_after_reset", lat, 32'd0);
    chk("idle_after_reset", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
